alu_ctrl_muldiv: RTL and testbench

Parametrised execute-stage control block for the multicycle RISC-V core. It decodes `ALU_Op`/`Funct3`/`Funct7` into a 4-bit ALU control for the full RV32I integer set. For RV32M operations it runs an iterative shift-add multiplier and restoring divider, and reports completion through a busy/done handshake. It sits between the main control FSM and the ALU; the control FSM holds the execute state until `done` arrives.

---
 rtl/alu_ctrl_muldiv.sv | 205 ++++++++++++++++++++
 tb/tb_alu_ctrl_muldiv.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_muldiv.sv
// Execute-stage control: RV32I ALU decode plus an iterative shift-add multiplier
// and restoring divider for RV32M, with a busy/done handshake to the control FSM.
//
// state  | meaning
// -------|-----------------------------------------------------------------
// IDLE   | waiting for start with is_md=1
// CALC   | one multiply/divide step per cycle until the counter expires
// FIXUP  | sign correction and result selection, md_result written on exit
// DONE   | done pulse for one cycle, then back to IDLE
module alu_ctrl_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       ALU_Op,
   input  logic [2:0]       Funct3,
   input  logic [6:0]       Funct7,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   input  logic             start,
   output logic [3:0]       ALUControl,
   output logic             is_md,
   output logic             illegal,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] md_result
);

   localparam int CW = $clog2(WIDTH) + 1;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLL  = 4'b0101;
   localparam logic [3:0] ALU_SRL  = 4'b0110;
   localparam logic [3:0] ALU_SRA  = 4'b0111;
   localparam logic [3:0] ALU_SLT  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

   function automatic logic [3:0] f3_map(input logic [2:0] f3);
      case (f3)
         3'b000:  f3_map = ALU_ADD;
         3'b001:  f3_map = ALU_SLL;
         3'b010:  f3_map = ALU_SLT;
         3'b011:  f3_map = ALU_SLTU;
         3'b100:  f3_map = ALU_XOR;
         3'b101:  f3_map = ALU_SRL;
         3'b110:  f3_map = ALU_OR;
         default: f3_map = ALU_AND;
      endcase
   endfunction

   always_comb begin
      is_md      = (ALU_Op == 2'b10) && (Funct7 == 7'b0000001);
      ALUControl = ALU_ADD;
      illegal    = 1'b0;
      case (ALU_Op)
         2'b00: ALUControl = ALU_ADD;
         2'b01: ALUControl = ALU_SUB;
         2'b10: begin
            if (is_md) begin
               ALUControl = ALU_ADD;
            end else if (Funct7 == 7'b0000000) begin
               ALUControl = f3_map(Funct3);
            end else if (Funct7 == 7'b0100000) begin
               if (Funct3 == 3'b000)      ALUControl = ALU_SUB;
               else if (Funct3 == 3'b101) ALUControl = ALU_SRA;
               else                       illegal    = 1'b1;
            end else begin
               illegal = 1'b1;
            end
         end
         default: begin
            if (Funct3 == 3'b101 && Funct7[5]) ALUControl = ALU_SRA;
            else                               ALUControl = f3_map(Funct3);
         end
      endcase
   end

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     opnd_q, opnd_d;
   logic [2:0]           op_q, op_d;
   logic                 neg_q, neg_d;
   logic                 rem_neg_q, rem_neg_d;
   logic                 zero_q, zero_d;
   logic [WIDTH-1:0]     result_q, result_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   logic                 a_signed, b_signed, a_sgn, b_sgn;
   logic [WIDTH-1:0]     a_mag, b_mag;
   logic [WIDTH:0]       mul_sum, div_shift, div_diff;
   logic [2*WIDTH-1:0]   prod;
   logic [WIDTH-1:0]     quot, remd;

   // Signedness per funct3: mul/mulh/div/rem fully signed, mulhsu signs only SrcA.
   always_comb begin
      a_signed  = (Funct3 == 3'b000) || (Funct3 == 3'b001) || (Funct3 == 3'b010) ||
                  (Funct3 == 3'b100) || (Funct3 == 3'b110);
      b_signed  = (Funct3 == 3'b000) || (Funct3 == 3'b001) ||
                  (Funct3 == 3'b100) || (Funct3 == 3'b110);
      a_sgn     = a_signed && SrcA[WIDTH-1];
      b_sgn     = b_signed && SrcB[WIDTH-1];
      a_mag     = a_sgn ? -SrcA : SrcA;
      b_mag     = b_sgn ? -SrcB : SrcB;
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                  (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
      div_shift = acc_q[2*WIDTH-1:WIDTH-1];
      div_diff  = div_shift - {1'b0, opnd_q};
      prod      = neg_q ? -acc_q : acc_q;
      quot      = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      remd      = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      op_d      = op_q;
      neg_d     = neg_q;
      rem_neg_d = rem_neg_q;
      zero_d    = zero_q;
      result_d  = result_q;
      case (state_q)
         S_IDLE: begin
            if (start && is_md) begin
               op_d      = Funct3;
               opnd_d    = Funct3[2] ? b_mag : a_mag;
               acc_d     = {{WIDTH{1'b0}}, (Funct3[2] ? a_mag : b_mag)};
               neg_d     = a_sgn ^ b_sgn;
               rem_neg_d = a_sgn;
               zero_d    = (SrcB == '0);
               cnt_d     = CW'(WIDTH);
               state_d   = S_CALC;
            end
         end
         S_CALC: begin
            if (cnt_q == '0) begin
               state_d = S_FIXUP;
            end else begin
               cnt_d = cnt_q - 1'b1;
               if (!op_q[2]) begin
                  acc_d = {mul_sum, acc_q[WIDTH-1:1]};
               end else if (!div_diff[WIDTH]) begin
                  acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
               end else begin
                  acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
               end
            end
         end
         S_FIXUP: begin
            // Divide-by-zero quotient is all ones regardless of operand signs.
            if (!op_q[2])            result_d = (op_q[1:0] == 2'b00) ? prod[WIDTH-1:0]
                                                                     : prod[2*WIDTH-1:WIDTH];
            else if (op_q[1])        result_d = remd;
            else if (zero_q)         result_d = '1;
            else                     result_d = quot;
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d == S_CALC) || (state_d == S_FIXUP);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         opnd_q    <= '0;
         op_q      <= '0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         zero_q    <= 1'b0;
         result_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opnd_q    <= opnd_d;
         op_q      <= op_d;
         neg_q     <= neg_d;
         rem_neg_q <= rem_neg_d;
         zero_q    <= zero_d;
         result_q  <= result_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign md_result = result_q;

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Bench for alu_ctrl_muldiv: WIDTH=32 and WIDTH=8 instances driven side by side
// and checked against an arithmetic reference model.
module tb_alu_ctrl_muldiv;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  alu_op = 2'b00;
   logic [2:0]  f3 = 3'b000;
   logic [6:0]  f7 = 7'b0000000;
   logic        start = 1'b0;
   logic [31:0] a32 = '0, b32 = '0;
   logic [7:0]  a8 = '0, b8 = '0;

   logic [3:0]  ctrl32, ctrl8;
   logic        md32, md8, ill32, ill8, busy32, busy8, done32, done8;
   logic [31:0] res32;
   logic [7:0]  res8;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_ctrl_muldiv #(.WIDTH(32)) dut32 (
      .clk(clk), .rst(rst), .ALU_Op(alu_op), .Funct3(f3), .Funct7(f7),
      .SrcA(a32), .SrcB(b32), .start(start), .ALUControl(ctrl32), .is_md(md32),
      .illegal(ill32), .busy(busy32), .done(done32), .md_result(res32));

   alu_ctrl_muldiv #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .ALU_Op(alu_op), .Funct3(f3), .Funct7(f7),
      .SrcA(a8), .SrcB(b8), .start(start), .ALUControl(ctrl8), .is_md(md8),
      .illegal(ill8), .busy(busy8), .done(done8), .md_result(res8));

   function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [63:0] a,
                                          input logic [63:0] b, input int w);
      logic signed [127:0] full, half, mask, ua, ub, sa, sb, r;
      full = 128'sd1 <<< w;
      half = full >>> 1;
      mask = full - 128'sd1;
      ua   = $signed({64'd0, a}) & mask;
      ub   = $signed({64'd0, b}) & mask;
      sa   = (ua >= half) ? ua - full : ua;
      sb   = (ub >= half) ? ub - full : ub;
      case (op)
         3'd0: r = sa * sb;
         3'd1: r = (sa * sb) >>> w;
         3'd2: r = (sa * ub) >>> w;
         3'd3: r = (ua * ub) >>> w;
         3'd4: if (ub == 0) r = mask; else if (sa == -half && sb == -1) r = half; else r = sa / sb;
         3'd5: if (ub == 0) r = mask; else r = ua / ub;
         3'd6: if (ub == 0) r = ua; else if (sa == -half && sb == -1) r = 0; else r = sa % sb;
         default: if (ub == 0) r = ua; else r = ua % ub;
      endcase
      r = r & mask;
      return r[63:0];
   endfunction

   // Returns {is_md, illegal, ALUControl}
   function automatic logic [5:0] ref_dec(input logic [1:0] op, input logic [2:0] fn3,
                                          input logic [6:0] fn7);
      logic [3:0] rmap [8];
      rmap = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
      case (op)
         2'd0: return 6'b00_0000;
         2'd1: return 6'b00_0001;
         2'd2: begin
            if (fn7 == 7'd1)  return 6'b10_0000;
            if (fn7 == 7'd0)  return {2'b00, rmap[fn3]};
            if (fn7 == 7'h20) begin
               if (fn3 == 3'd0) return 6'b00_0001;
               if (fn3 == 3'd5) return 6'b00_0111;
            end
            return 6'b01_0000;
         end
         default: begin
            if (fn3 == 3'd5) return fn7[5] ? 6'b00_0111 : 6'b00_0110;
            return {2'b00, rmap[fn3]};
         end
      endcase
   endfunction

   task automatic run_md(input logic [2:0] op, input logic [31:0] va32, input logic [31:0] vb32,
                         input logic [7:0] va8, input logic [7:0] vb8);
      logic [63:0] t;
      logic [31:0] e32, prev32;
      logic [7:0]  e8, prev8;
      logic        got32, got8, bz32, bz8;
      int          lat32, lat8;
      t = ref_md(op, {32'd0, va32}, {32'd0, vb32}, 32);
      e32 = t[31:0];
      t = ref_md(op, {56'd0, va8}, {56'd0, vb8}, 8);
      e8 = t[7:0];
      got32 = 0; got8 = 0; lat32 = 0; lat8 = 0; bz32 = 1; bz8 = 1;
      @(negedge clk);
      alu_op = 2'b10; f7 = 7'b0000001; f3 = op;
      a32 = va32; b32 = vb32; a8 = va8; b8 = vb8;
      start = 1'b1;
      prev32 = res32; prev8 = res8;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (busy32 !== 1'b1 || busy8 !== 1'b1)
         begin errors++; $display("FAIL busy_after_start: got %b/%b expected 1/1", busy32, busy8); end
      for (int i = 1; i <= 50 && !(got32 && got8); i++) begin
         @(posedge clk); #1;
         checks++;
         if (!got32) begin
            if (done32 === 1'b1) begin got32 = 1; lat32 = i; bz32 = busy32; end
            else if (busy32 !== 1'b1 || res32 !== prev32) begin
               errors++; $display("FAIL busy_hold32 op%0d cyc%0d: busy=%b res=%h expected busy=1 res=%h", op, i, busy32, res32, prev32);
            end
         end
         if (got8) begin
            if (done8 !== 1'b0) begin errors++; $display("FAIL done_pulse8: got %b expected 0", done8); end
         end else if (done8 === 1'b1) begin
            got8 = 1; lat8 = i; bz8 = busy8;
         end else if (busy8 !== 1'b1 || res8 !== prev8) begin
            errors++; $display("FAIL busy_hold8 op%0d cyc%0d: busy=%b res=%h expected busy=1 res=%h", op, i, busy8, res8, prev8);
         end
      end
      checks++;
      if (!got32 || !got8) begin
         errors++; $display("FAIL done_timeout op%0d: got32=%b got8=%b expected 1/1", op, got32, got8);
      end else begin
         checks++;
         if (lat32 != 34 || lat8 != 10)
            begin errors++; $display("FAIL latency op%0d: got %0d/%0d expected 34/10", op, lat32, lat8); end
         checks++;
         if (bz32 !== 1'b0 || bz8 !== 1'b0)
            begin errors++; $display("FAIL busy_during_done: got %b/%b expected 0/0", bz32, bz8); end
         checks++;
         if (res32 !== e32)
            begin errors++; $display("FAIL result32 op%0d %h,%h: got %h expected %h", op, va32, vb32, res32, e32); end
         checks++;
         if (res8 !== e8)
            begin errors++; $display("FAIL result8 op%0d %h,%h: got %h expected %h", op, va8, vb8, res8, e8); end
      end
      @(posedge clk); #1;
      checks++;
      if (done32 !== 1'b0 || busy32 !== 1'b0)
         begin errors++; $display("FAIL done_pulse32: done=%b busy=%b expected 0/0", done32, busy32); end
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if (busy32 !== 0 || done32 !== 0 || res32 !== 0 || busy8 !== 0 || done8 !== 0 || res8 !== 0)
         begin errors++; $display("FAIL reset_state: busy=%b%b done=%b%b res=%h/%h expected zeros", busy32, busy8, done32, done8, res32, res8); end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_decode();
      logic [6:0] f7set [4];
      logic [5:0] e;
      for (int op = 0; op < 4; op++)
         for (int fn = 0; fn < 8; fn++) begin
            f7set = '{7'h00, 7'h20, 7'h01, 7'($urandom)};
            for (int k = 0; k < 4; k++) begin
               alu_op = 2'(op); f3 = 3'(fn); f7 = f7set[k];
               #1;
               e = ref_dec(alu_op, f3, f7);
               checks++;
               if ({md32, ill32, ctrl32} !== e || {md8, ill8, ctrl8} !== e) begin
                  errors++;
                  $display("FAIL decode op=%0d f3=%0d f7=%h: got %b/%b expected %b", op, fn, f7, {md32, ill32, ctrl32}, {md8, ill8, ctrl8}, e);
               end
            end
         end
      alu_op = 2'b10; f3 = 3'b000; f7 = 7'b0100000; #1;
      checks++;
      if (ctrl32 !== 4'b0001) begin errors++; $display("FAIL dec_sub: got %b expected 0001", ctrl32); end
      alu_op = 2'b11; f3 = 3'b101; f7 = 7'b0100000; #1;
      checks++;
      if (ctrl32 !== 4'b0111) begin errors++; $display("FAIL dec_srai: got %b expected 0111", ctrl32); end
      alu_op = 2'b10; f3 = 3'b001; f7 = 7'b0100000; #1;
      checks++;
      if (ill32 !== 1'b1) begin errors++; $display("FAIL dec_illegal: got %b expected 1", ill32); end
   endtask

   task automatic test_mul();
      run_md(3'd0, 32'd7, -32'sd3, 8'd7, -8'sd3);
      checks++;
      if (res32 !== 32'hFFFFFFEB || res8 !== 8'hEB)
         begin errors++; $display("FAIL mul_7x-3: got %h/%h expected FFFFFFEB/EB", res32, res8); end
      run_md(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'hFF, 8'hFF);
      checks++;
      if (res32 !== 32'h0 || res8 !== 8'h0)
         begin errors++; $display("FAIL mulh_-1x-1: got %h/%h expected 0/0", res32, res8); end
      run_md(3'd3, 32'hFFFFFFFF, 32'd2, 8'hFF, 8'd2);
      checks++;
      if (res32 !== 32'h1 || res8 !== 8'h1)
         begin errors++; $display("FAIL mulhu_max_x2: got %h/%h expected 1/1", res32, res8); end
   endtask

   task automatic test_div();
      run_md(3'd4, -32'sd7, 32'd2, -8'sd7, 8'd2);
      checks++;
      if (res32 !== 32'hFFFFFFFD || res8 !== 8'hFD)
         begin errors++; $display("FAIL div_-7/2: got %h/%h expected FFFFFFFD/FD", res32, res8); end
      run_md(3'd6, -32'sd7, 32'd2, -8'sd7, 8'd2);
      checks++;
      if (res32 !== 32'hFFFFFFFF || res8 !== 8'hFF)
         begin errors++; $display("FAIL rem_-7/2: got %h/%h expected FFFFFFFF/FF", res32, res8); end
      run_md(3'd5, 32'd100, 32'd7, 8'd100, 8'd7);
      checks++;
      if (res32 !== 32'd14 || res8 !== 8'd14)
         begin errors++; $display("FAIL divu_100/7: got %0d/%0d expected 14/14", res32, res8); end
      run_md(3'd7, 32'd100, 32'd7, 8'd100, 8'd7);
      checks++;
      if (res32 !== 32'd2 || res8 !== 8'd2)
         begin errors++; $display("FAIL remu_100/7: got %0d/%0d expected 2/2", res32, res8); end
   endtask

   task automatic test_special();
      run_md(3'd4, 32'd5, 32'd0, 8'd5, 8'd0);
      checks++;
      if (res32 !== 32'hFFFFFFFF || res8 !== 8'hFF)
         begin errors++; $display("FAIL div_by_zero: got %h/%h expected FFFFFFFF/FF", res32, res8); end
      run_md(3'd6, 32'd5, 32'd0, 8'd5, 8'd0);
      checks++;
      if (res32 !== 32'd5 || res8 !== 8'd5)
         begin errors++; $display("FAIL rem_by_zero: got %h/%h expected 5/5", res32, res8); end
      run_md(3'd4, 32'h80000000, 32'hFFFFFFFF, 8'h80, 8'hFF);
      checks++;
      if (res32 !== 32'h80000000 || res8 !== 8'h80)
         begin errors++; $display("FAIL div_overflow: got %h/%h expected 80000000/80", res32, res8); end
      run_md(3'd6, 32'h80000000, 32'hFFFFFFFF, 8'h80, 8'hFF);
      checks++;
      if (res32 !== 32'h0 || res8 !== 8'h0)
         begin errors++; $display("FAIL rem_overflow: got %h/%h expected 0/0", res32, res8); end
   endtask

   task automatic test_random();
      logic [31:0] x, y;
      logic [7:0]  p, q;
      for (int n = 0; n < 32; n++) begin
         x = $urandom; y = $urandom; p = 8'($urandom); q = 8'($urandom);
         case ($urandom_range(0, 4))
            0: begin y = '0; q = '0; end
            1: begin x = 32'h80000000; y = '1; p = 8'h80; q = '1; end
            2: begin y = 32'($urandom_range(1, 15)); q = 8'($urandom_range(1, 15)); end
            default: ;
         endcase
         run_md(3'($urandom_range(0, 7)), x, y, p, q);
      end
   endtask

   task automatic test_busy_start();
      logic got;
      got = 0;
      @(negedge clk);
      alu_op = 2'b10; f7 = 7'b0000001; f3 = 3'd0;
      a32 = 32'd6; b32 = 32'd7; a8 = 8'd6; b8 = 8'd7; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      f3 = 3'd5; a32 = 32'd1000; b32 = 32'd3; a8 = 8'd200; b8 = 8'd3; start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(posedge clk); #1;
         if (done32 === 1'b1) got = 1;
      end
      checks++;
      if (!got) begin errors++; $display("FAIL busy_start_timeout: got no done expected done"); end
      checks++;
      if (res32 !== 32'd42 || res8 !== 8'd42)
         begin errors++; $display("FAIL start_while_busy: got %0d/%0d expected 42/42", res32, res8); end
      @(posedge clk); #1;
   endtask

   task automatic test_non_md_start();
      @(negedge clk);
      alu_op = 2'b10; f7 = 7'b0000000; f3 = 3'd0; start = 1'b1;
      @(negedge clk);
      alu_op = 2'b11; f7 = 7'b0000001;
      @(negedge clk); start = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         checks++;
         if (busy32 !== 1'b0 || busy8 !== 1'b0)
            begin errors++; $display("FAIL non_md_start: got busy %b/%b expected 0/0", busy32, busy8); end
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      alu_op = 2'b10; f7 = 7'b0000001; f3 = 3'd1;
      a32 = $urandom; b32 = $urandom; a8 = 8'($urandom); b8 = 8'($urandom); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (10) @(posedge clk);
      #2; rst = 1'b0; #1;
      checks++;
      if (busy32 !== 0 || done32 !== 0 || res32 !== 0 || busy8 !== 0 || done8 !== 0 || res8 !== 0)
         begin errors++; $display("FAIL reset_mid_calc: busy=%b%b done=%b%b res=%h/%h expected zeros", busy32, busy8, done32, done8, res32, res8); end
      @(negedge clk); rst = 1'b1;
      run_md(3'd2, -32'sd12345, 32'hF0000001, -8'sd45, 8'hF1);
   endtask

   task automatic test_back_to_back();
      run_md(3'd0, 32'd123456, 32'd789, 8'd12, 8'd9);
      run_md(3'd7, 32'd123456, 32'd789, 8'd250, 8'd9);
      run_md(3'd4, -32'sd1000, 32'd33, -8'sd100, 8'd7);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_decode();
      test_mul();
      test_div();
      test_special();
      test_busy_start();
      test_non_md_start();
      test_random();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
